// File: rtl/pulse_synch_pkg.sv
// Shared types and default parameters for the pulse synchronizer transmit side.
package pulse_synch_pkg;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned PEND_W_DEF      = 4;

  // Four-phase handshake states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ_HI = 2'd1,
    ST_REQ_LO = 2'd2
  } state_e;

endpackage

// File: rtl/bit_synch.sv
// Multi-flop single-bit synchronizer; also used by the slow-side receiver.
module bit_synch #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/pulse_synch_tx.sv
// Fast-domain side of a pulse synchronizer: queues single-cycle events and
// sends each one as a four-phase req/ack handshake to a slow-domain receiver.
module pulse_synch_tx
  import pulse_synch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned PEND_W      = PEND_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pulse,
  input  logic              i_ack,
  output logic              o_req,
  output logic              o_busy,
  output logic [PEND_W-1:0] o_pending,
  output logic              o_done,
  output logic              o_overflow
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_req;
  logic              r_busy;
  logic              r_done;
  logic              r_overflow;
  logic [PEND_W-1:0] r_pending;

  logic              w_ack_s;
  logic              w_start;
  logic              w_done;
  logic              w_inc;
  logic              w_dec;
  logic              w_overflow;
  logic [PEND_W-1:0] w_pending_nxt;

  // Bring the receiver acknowledge into this clock domain.
  bit_synch #(
    .STAGES (SYNC_STAGES)
  ) u_ack_synch (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_ack),
    .o_q   (w_ack_s)
  );

  // Next-state, completion and pending-counter update.
  always_comb begin
    w_state_nxt   = r_state;
    w_start       = 1'b0;
    w_done        = 1'b0;
    w_inc         = 1'b0;
    w_dec         = 1'b0;
    w_overflow    = 1'b0;
    w_pending_nxt = r_pending;

    case (r_state)
      ST_IDLE: begin
        if (i_pulse || (r_pending != '0)) begin
          w_state_nxt = ST_REQ_HI;
          w_start     = 1'b1;
        end
      end
      ST_REQ_HI: begin
        if (w_ack_s) begin
          w_state_nxt = ST_REQ_LO;
        end
      end
      ST_REQ_LO: begin
        if (!w_ack_s) begin
          w_done = 1'b1;
          if (i_pulse || (r_pending != '0)) begin
            w_state_nxt = ST_REQ_HI;
            w_start     = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // A pulse arriving as a transfer starts is sent directly; otherwise the
    // start drains one queued event and any pulse is queued.
    w_dec      = w_start && !i_pulse;
    w_inc      = i_pulse && !w_start;
    w_overflow = w_inc && (r_pending == PEND_MAX);

    if (w_dec) begin
      w_pending_nxt = r_pending - PEND_W'(1);
    end else if (w_inc && !w_overflow) begin
      w_pending_nxt = r_pending + PEND_W'(1);
    end
  end

  // State and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_req      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_pending  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_req      <= (w_state_nxt == ST_REQ_HI);
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_done     <= w_done;
      r_overflow <= w_overflow;
      r_pending  <= w_pending_nxt;
    end
  end

  assign o_req      = r_req;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_overflow = r_overflow;
  assign o_pending  = r_pending;

endmodule

// File: doc/pulse_synch_tx.md
PULSE_SYNCH_TX -- requirements
Module: pulse_synch_tx

Interface
REQ-001 Parameter SYNC_STAGES, default 2, is the number of flops in the ack synchronizer (legal values 2..4).
REQ-002 Parameter PEND_W, default 4, is the width of the pending-pulse counter.
REQ-003 i_clk, input, 1: source (fast) domain clock; the only clock in the block.
REQ-004 i_rst, input, 1: synchronous, active-high reset.
REQ-005 i_pulse, input, 1: single-cycle event to transfer to the slow domain.
REQ-006 i_ack, input, 1: handshake acknowledge from slow-domain receiver; asynchronous to i_clk.
REQ-007 o_req, output, 1: registered handshake request level, crosses to the slow domain.
REQ-008 o_busy, output, 1: high while a transfer is in flight (FSM not IDLE).
REQ-009 o_pending, output, PEND_W: count of accepted events awaiting transfer.
REQ-010 o_done, output, 1: one-cycle pulse when a transfer completes.
REQ-011 o_overflow, output, 1: one-cycle pulse when an event is dropped.

Function
REQ-012 i_ack SHALL pass through a SYNC_STAGES flop chain before any use; ack_s denotes its output.
REQ-013 The FSM SHALL use a four-phase handshake with states IDLE, REQ_HI, REQ_LO.
REQ-014 In IDLE, when i_pulse=1 or o_pending>0, the FSM SHALL go to REQ_HI and drive o_req=1 from the next cycle.
REQ-015 When leaving IDLE on o_pending>0 with i_pulse=0, o_pending SHALL decrement by 1.
REQ-016 In REQ_HI, o_req SHALL stay 1 until ack_s=1, then go to REQ_LO with o_req=0 the next cycle.
REQ-017 In REQ_LO, when ack_s=0, the FSM SHALL pulse o_done for one cycle and go to IDLE.
REQ-018 In REQ_LO, when ack_s=0 and (o_pending>0 or i_pulse=1), the FSM SHALL go directly to REQ_HI (back-to-back transfer).
REQ-019 That back-to-back step SHALL still pulse o_done and SHALL decrement o_pending when no new i_pulse is consumed directly.
REQ-020 i_pulse while busy SHALL increment o_pending.
REQ-021 i_pulse in a cycle that also consumes a pending event SHALL leave o_pending unchanged (net zero).
REQ-022 i_pulse with o_pending = 2^PEND_W-1 and no same-cycle decrement SHALL leave the count unchanged and pulse o_overflow.
REQ-023 The counter SHALL never wrap.
REQ-024 Latency: i_pulse in IDLE at cycle N SHALL give o_req=1 at N+1.
REQ-025 Each transfer SHALL be exactly one o_req rising edge; events SHALL never merge except on overflow.
REQ-026 All outputs SHALL be registered; o_busy SHALL equal (state != IDLE).

Reset
REQ-027 On i_rst=1 at a clock edge, state SHALL be IDLE and o_req, o_busy, o_done, o_overflow and o_pending SHALL all be 0.
REQ-028 The synchronizer flops SHALL also be cleared on reset.
REQ-029 Reset mid-transfer SHALL drop o_req the following cycle and discard pending events.
REQ-030 The slow-side receiver SHALL be reset with the same system reset event.
REQ-031 i_pulse while i_rst=1 SHALL be ignored.

Structure
REQ-032 Package pulse_synch_pkg SHALL hold the FSM state enum typedef and the default values of SYNC_STAGES and PEND_W.
REQ-033 The ack synchronizer SHALL be a sub-module bit_synch, parameterized by stage count.
REQ-034 bit_synch SHALL be reused by the slow-side receiver.
REQ-035 No other sub-modules are needed.

Verification
REQ-036 Single event: reset, i_pulse at cycle 10, ack model returns i_ack 3 slow cycles after o_req -> o_req rises at cycle 11, one o_done, o_pending stays 0.
REQ-037 Burst: 5 consecutive i_pulse cycles -> 5 distinct o_req rising edges, o_pending peaks at 4, 5 o_done pulses, ends IDLE.
REQ-038 Overflow, PEND_W=2: 6 i_pulse while i_ack is held low -> o_pending saturates at 3, exactly 2 o_overflow pulses, 4 transfers after ack resumes.
REQ-039 Simultaneous: i_pulse in the same cycle REQ_LO sees ack_s=0 with o_pending=2 -> o_pending remains 2, immediate REQ_HI, o_done pulses.
REQ-040 Reset mid-operation: i_rst asserted in REQ_HI with o_pending=3 -> next cycle o_req=0, o_pending=0, o_busy=0; a subsequent i_pulse gives a normal transfer.
REQ-041 Asynchronous ack: i_ack randomly phased against i_clk (ratio 7:3) over 1000 events -> o_req edge count equals accepted events, no X on outputs.
